// File: rtl/cw305_usb_bus_master.sv
// -----------------------------------------------------------------------------
// cw305_usb_bus_master
//   Drives a byte-wide asynchronous SRAM-style bus (nCS / nRD / nWE) from a
//   valid/ready command interface. Each command runs one bus cycle with
//   programmable setup, strobe and hold lengths, then pulses rsp_valid.
//
// Ports
//   usb_clk, rst        : clock and synchronous active-high reset
//   cmd_valid/cmd_ready : command handshake; cmd_write/cmd_addr/cmd_wdata are
//                         the command fields, sampled only on acceptance
//   rsp_valid           : one-cycle pulse when a bus cycle completes
//   rsp_rdata           : most recently captured read byte
//   busy                : high while a bus cycle is in progress
//   usb_addr/usb_dout   : registered address and write data
//   usb_din             : read data from the bus
//   usb_drive           : data-bus output enable (writes only)
//   usb_cen/rdn/wrn     : active-low chip enable, read and write strobes
// -----------------------------------------------------------------------------
module cw305_usb_bus_master #(
  parameter int pADDR_WIDTH    = 21,
  parameter int pSETUP_CYCLES  = 1,
  parameter int pSTROBE_CYCLES = 2,
  parameter int pHOLD_CYCLES   = 1
) (
  input  logic                   usb_clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   cmd_write,
  input  logic [pADDR_WIDTH-1:0] cmd_addr,
  input  logic [7:0]             cmd_wdata,
  output logic                   rsp_valid,
  output logic [7:0]             rsp_rdata,
  output logic                   busy,
  output logic [pADDR_WIDTH-1:0] usb_addr,
  output logic [7:0]             usb_dout,
  input  logic [7:0]             usb_din,
  output logic                   usb_drive,
  output logic                   usb_rdn,
  output logic                   usb_wrn,
  output logic                   usb_cen
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } state_e;

  localparam logic [3:0] S_CNT = 4'(pSETUP_CYCLES);
  localparam logic [3:0] P_CNT = 4'(pSTROBE_CYCLES);
  localparam logic [3:0] H_CNT = 4'(pHOLD_CYCLES);

  state_e                   state_q, state_d;
  logic [3:0]               cnt_q, cnt_d;
  // ready_q keeps cmd_ready low during reset and rises one cycle after it.
  logic                     ready_q, ready_d;
  logic                     wr_q, wr_d;
  logic [pADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [7:0]               wdata_q, wdata_d;
  logic [7:0]               rdata_q, rdata_d;
  logic                     rsp_valid_q, rsp_valid_d;
  logic                     cen_q, cen_d;
  logic                     rdn_q, rdn_d;
  logic                     wrn_q, wrn_d;
  logic                     drive_q, drive_d;
  logic                     last_cycle;

  assign last_cycle = (cnt_q == 4'd1);

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    ready_d     = 1'b1;
    wr_d        = wr_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    rsp_valid_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (cmd_valid && ready_q) begin
          wr_d    = cmd_write;
          addr_d  = cmd_addr;
          wdata_d = cmd_wdata;
          state_d = SETUP;
          cnt_d   = S_CNT;
        end
      end
      SETUP: begin
        if (last_cycle) begin
          state_d = STROBE;
          cnt_d   = P_CNT;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      STROBE: begin
        if (last_cycle) begin
          // Sample read data at the end of the final strobe cycle, just
          // before nRD is released.
          if (!wr_q) rdata_d = usb_din;
          state_d = HOLD;
          cnt_d   = H_CNT;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      HOLD: begin
        if (last_cycle) begin
          state_d     = IDLE;
          cnt_d       = 4'd0;
          rsp_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase

    // Bus controls are decoded from the next state so they come straight
    // out of flops, aligned with the state they belong to.
    cen_d   = (state_d == IDLE);
    drive_d = (state_d != IDLE) && wr_d;
    rdn_d   = !((state_d == STROBE) && !wr_d);
    wrn_d   = !((state_d == STROBE) && wr_d);
  end

  always_ff @(posedge usb_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      ready_q     <= 1'b0;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= 8'h00;
      rdata_q     <= 8'h00;
      rsp_valid_q <= 1'b0;
      cen_q       <= 1'b1;
      rdn_q       <= 1'b1;
      wrn_q       <= 1'b1;
      drive_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ready_q     <= ready_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      rsp_valid_q <= rsp_valid_d;
      cen_q       <= cen_d;
      rdn_q       <= rdn_d;
      wrn_q       <= wrn_d;
      drive_q     <= drive_d;
    end
  end

  assign cmd_ready = (state_q == IDLE) && ready_q;
  assign busy      = (state_q != IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;
  // The latched command registers double as the bus address/data drivers,
  // so they naturally hold their last values while idle.
  assign usb_addr  = addr_q;
  assign usb_dout  = wdata_q;
  assign usb_drive = drive_q;
  assign usb_rdn   = rdn_q;
  assign usb_wrn   = wrn_q;
  assign usb_cen   = cen_q;

endmodule

// File: tb/tb_cw305_usb_bus_master.sv
// -----------------------------------------------------------------------------
// tb_cw305_usb_bus_master
//   Two instances: u_dut0 with default timing (S=1,P=2,H=1) and u_dut1 with
//   S=3,P=4,H=2. A reference model tracks each transaction as a cycle offset
//   from its acceptance edge and derives every expected output from that.
// -----------------------------------------------------------------------------
module tb_cw305_usb_bus_master;

  localparam int AW = 21;

  typedef struct {
    int          t;      // cycle offset within a transaction, -1 when idle
    bit          ready;  // at least one non-reset edge seen
    bit          wr;
    logic [20:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
    bit          rspv;
  } model_t;

  logic usb_clk = 1'b0;
  logic rst     = 1'b1;

  logic          v0 = 0, w0 = 0, v1 = 0, w1 = 0;
  logic [AW-1:0] a0 = '0, a1 = '0;
  logic [7:0]    wd0 = 0, wd1 = 0, din0 = 0, din1 = 0;

  logic          rdy0, rv0, busy0, drv0, rdn0, wrn0, cen0;
  logic [7:0]    rd0, dout0;
  logic [AW-1:0] ua0;
  logic          rdy1, rv1, busy1, drv1, rdn1, wrn1, cen1;
  logic [7:0]    rd1, dout1;
  logic [AW-1:0] ua1;

  int tests = 0;
  int fails = 0;

  model_t m0, m1;

  always #5 usb_clk = ~usb_clk;

  cw305_usb_bus_master u_dut0 (
    .usb_clk(usb_clk), .rst(rst), .cmd_valid(v0), .cmd_ready(rdy0),
    .cmd_write(w0), .cmd_addr(a0), .cmd_wdata(wd0), .rsp_valid(rv0),
    .rsp_rdata(rd0), .busy(busy0), .usb_addr(ua0), .usb_dout(dout0),
    .usb_din(din0), .usb_drive(drv0), .usb_rdn(rdn0), .usb_wrn(wrn0),
    .usb_cen(cen0)
  );

  cw305_usb_bus_master #(
    .pADDR_WIDTH(AW), .pSETUP_CYCLES(3), .pSTROBE_CYCLES(4), .pHOLD_CYCLES(2)
  ) u_dut1 (
    .usb_clk(usb_clk), .rst(rst), .cmd_valid(v1), .cmd_ready(rdy1),
    .cmd_write(w1), .cmd_addr(a1), .cmd_wdata(wd1), .rsp_valid(rv1),
    .rsp_rdata(rd1), .busy(busy1), .usb_addr(ua1), .usb_dout(dout1),
    .usb_din(din1), .usb_drive(drv1), .usb_rdn(rdn1), .usb_wrn(wrn1),
    .usb_cen(cen1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance the model across one clock edge using the inputs seen at it.
  function automatic void model_edge(inout model_t m, input int s, input int p,
                                     input int h, input logic r, input logic v,
                                     input logic w, input logic [20:0] a,
                                     input logic [7:0] wd, input logic [7:0] din);
    if (r) begin
      m.t = -1; m.ready = 0; m.wr = 0; m.addr = '0; m.wdata = '0;
      m.rdata = '0; m.rspv = 0;
    end else begin
      m.rspv = 0;
      if (m.t >= 1) begin
        if (m.t == s + p && !m.wr) m.rdata = din;
        if (m.t == s + p + h) begin
          m.rspv = 1;
          m.t    = -1;
        end else begin
          m.t++;
        end
      end else begin
        if (m.ready && v) begin
          m.wr = w; m.addr = a; m.wdata = wd; m.t = 1;
        end
      end
      m.ready = 1;
    end
  endfunction

  task automatic check_dut(input string n, input model_t m, input int s, input int p,
                           input logic rdy, input logic bsy, input logic cen,
                           input logic rdn, input logic wrn, input logic drv,
                           input logic [20:0] ua, input logic [7:0] dout,
                           input logic rv, input logic [7:0] rd);
    bit in_tr, strobe;
    in_tr  = (m.t >= 1);
    strobe = (m.t >= s + 1) && (m.t <= s + p);
    chk({n, " cmd_ready"}, 32'(rdy), 32'(!in_tr && m.ready));
    chk({n, " busy"},      32'(bsy), 32'(in_tr));
    chk({n, " usb_cen"},   32'(cen), 32'(!in_tr));
    chk({n, " usb_rdn"},   32'(rdn), 32'(!(strobe && !m.wr)));
    chk({n, " usb_wrn"},   32'(wrn), 32'(!(strobe && m.wr)));
    chk({n, " usb_drive"}, 32'(drv), 32'(in_tr && m.wr));
    chk({n, " usb_addr"},  32'(ua),  32'(m.addr));
    chk({n, " usb_dout"},  32'(dout), 32'(m.wdata));
    chk({n, " rsp_valid"}, 32'(rv),  32'(m.rspv));
    chk({n, " rsp_rdata"}, 32'(rd),  32'(m.rdata));
  endtask

  task automatic step();
    @(posedge usb_clk);
    model_edge(m0, 1, 2, 1, rst, v0, w0, a0, wd0, din0);
    model_edge(m1, 3, 4, 2, rst, v1, w1, a1, wd1, din1);
    #1;
    check_dut("dut0", m0, 1, 2, rdy0, busy0, cen0, rdn0, wrn0, drv0, ua0, dout0, rv0, rd0);
    check_dut("dut1", m1, 3, 4, rdy1, busy1, cen1, rdn1, wrn1, drv1, ua1, dout1, rv1, rd1);
  endtask

  initial begin
    int n, rdn_low, cen_low, lat;
    m0 = '{t: -1, ready: 0, wr: 0, addr: '0, wdata: '0, rdata: '0, rspv: 0};
    m1 = m0;

    // Reset state, including cmd_ready held low while rst is high.
    rst = 1;
    repeat (3) step();
    chk("reset cmd_ready0", 32'(rdy0), 32'd0);
    rst = 0;
    step();
    chk("ready after reset", 32'(rdy0), 32'd1);

    // Default write: addr 0x000005, data 0xA5.
    v0 = 1; w0 = 1; a0 = 21'h000005; wd0 = 8'hA5;
    step();
    chk("wr accepted", 32'(m0.t), 32'd1);
    v0 = 0; a0 = '1; wd0 = 8'hFF;
    for (n = 0; n < 20 && !m0.rspv; n++) step();
    chk("wr rsp latency", 32'(n), 32'd4);

    // Default read: addr 0x000102, din 0x3C, then a write must keep rsp_rdata.
    v0 = 1; w0 = 0; a0 = 21'h000102; din0 = 8'h3C;
    step();
    v0 = 0;
    for (n = 0; n < 20 && !m0.rspv; n++) step();
    chk("rd rsp latency", 32'(n), 32'd4);
    chk("rd rdata", 32'(rd0), 32'h3C);
    din0 = 8'h99;
    v0 = 1; w0 = 1; a0 = 21'h1ABCDE; wd0 = 8'h5A;
    step();
    v0 = 0;
    for (n = 0; n < 20 && !m0.rspv; n++) step();
    chk("rdata kept over write", 32'(rd0), 32'h3C);

    // Back-to-back: valid held high, read followed by write.
    v0 = 1; w0 = 0; a0 = 21'h000777; din0 = 8'hC3;
    step();
    w0 = 1; a0 = 21'h000888; wd0 = 8'h42;
    for (n = 0; n < 20 && !m0.rspv; n++) step();
    chk("b2b rsp and ready", {30'd0, rv0, rdy0}, 32'd3);
    chk("b2b cen gap", 32'(cen0), 32'd1);
    step();
    chk("b2b second accept", 32'(m0.t), 32'd1);
    chk("b2b cen low again", 32'(cen0), 32'd0);
    v0 = 0;
    for (n = 0; n < 20 && !m0.rspv; n++) step();
    chk("b2b second rsp", 32'(rv0), 32'd1);

    // Long timing on dut1: din changes on the 3rd strobe cycle and is captured.
    v1 = 1; w1 = 0; a1 = 21'h0ABCDE; din1 = 8'h11;
    step();
    v1 = 0;
    rdn_low = (rdn1 == 0) ? 1 : 0;
    cen_low = (cen1 == 0) ? 1 : 0;
    lat = 1;
    for (n = 0; n < 30 && !m1.rspv; n++) begin
      if (m1.t == 6) din1 = 8'h77;
      step();
      lat++;
      if (rdn1 == 0) rdn_low++;
      if (cen1 == 0) cen_low++;
    end
    chk("p rsp at k+10", 32'(lat), 32'd10);
    chk("p rdn low cycles", 32'(rdn_low), 32'd4);
    chk("p cen low cycles", 32'(cen_low), 32'd9);
    chk("p rdata late din", 32'(rd1), 32'h77);

    // Reset during the strobe of a write aborts and releases the bus.
    v0 = 1; w0 = 1; a0 = 21'h000033; wd0 = 8'hE7;
    step();
    v0 = 0;
    for (n = 0; n < 20 && m0.t != 2; n++) step();
    chk("in strobe", 32'(wrn0), 32'd0);
    rst = 1;
    step();
    chk("abort wrn", 32'(wrn0), 32'd1);
    chk("abort cen", 32'(cen0), 32'd1);
    chk("abort drive", 32'(drv0), 32'd0);
    chk("abort rsp_valid", 32'(rv0), 32'd0);
    chk("abort rdata", 32'(rd0), 32'd0);
    rst = 0;
    step();
    chk("abort rsp_valid after", 32'(rv0), 32'd0);
    chk("ready after abort", 32'(rdy0), 32'd1);

    // Random traffic on both instances, with occasional resets.
    for (int i = 0; i < 600; i++) begin
      rst  = ($urandom_range(0, 149) == 0);
      v0   = $urandom_range(0, 1) == 1;
      w0   = $urandom_range(0, 1) == 1;
      a0   = AW'($urandom);
      wd0  = 8'($urandom);
      din0 = 8'($urandom);
      v1   = $urandom_range(0, 2) != 0;
      w1   = $urandom_range(0, 1) == 1;
      a1   = AW'($urandom);
      wd1  = 8'($urandom);
      din1 = 8'($urandom);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
